// File: rtl/rca_selfrepair.sv
// rtl/rca_selfrepair.sv - ripple-carry adder with BIST and spare-cell remapping
// A WIDTH-bit ripple adder built from CELLS physical full-adder cells, of which any WIDTH are selected by a map.
module rca_selfrepair #(
  parameter int WIDTH  = 4,
  parameter int SPARES = 2,
  localparam int CELLS = WIDTH + SPARES,
  localparam int CW    = $clog2(CELLS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [CELLS-1:0] fi_mask,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             ready,
  output logic             fail,
  output logic [CELLS-1:0] fault_map,
  output logic [CW-1:0]    fault_cnt
);

  localparam int IW = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [IW-1:0] LAST_CELL = IW'(CELLS - 1);
  localparam logic [CW-1:0] SPARES_W  = CW'(SPARES);

  typedef enum logic [2:0] {S_IDLE, S_TEST, S_MAP, S_READY, S_FAIL} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     c_q, c_d;
  logic [2:0]        p_q, p_d;
  logic [CELLS-1:0]  fault_map_q, fault_map_d;
  logic [CW-1:0]     fault_cnt_q, fault_cnt_d;
  logic [IW-1:0]     map_q [WIDTH];
  logic [IW-1:0]     map_d [WIDTH];
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;

  logic [WIDTH-1:0]  add_sum;
  logic              add_carry;
  logic              add_flip;
  logic              cell_s, cell_c, gold_s, gold_c, test_bad;
  logic [CW-1:0]     pop_cnt;
  logic [IW-1:0]     heal_map [WIDTH];
  int                heal_j;

  // Datapath: logical bit i runs through physical cell map_q[i]; a faulty cell inverts both outputs.
  always_comb begin
    add_sum   = '0;
    add_carry = cin;
    add_flip  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      add_flip   = fi_mask[map_q[i]];
      add_sum[i] = a[i] ^ b[i] ^ add_carry ^ add_flip;
      add_carry  = ((a[i] & b[i]) | (a[i] & add_carry) | (b[i] & add_carry)) ^ add_flip;
    end
  end

  always_comb begin
    gold_s   = p_q[2] ^ p_q[1] ^ p_q[0];
    gold_c   = (p_q[2] & p_q[1]) | (p_q[2] & p_q[0]) | (p_q[1] & p_q[0]);
    cell_s   = gold_s ^ fi_mask[c_q];
    cell_c   = gold_c ^ fi_mask[c_q];
    test_bad = (cell_s != gold_s) || (cell_c != gold_c);
  end

  // Healthy cells are packed into logical positions in ascending physical order.
  always_comb begin
    pop_cnt = '0;
    heal_j  = 0;
    for (int i = 0; i < WIDTH; i++) heal_map[i] = '0;
    for (int k = 0; k < CELLS; k++) begin
      pop_cnt = pop_cnt + CW'(fault_map_q[k]);
      if (!fault_map_q[k] && heal_j < WIDTH) begin
        heal_map[heal_j] = IW'(k);
        heal_j = heal_j + 1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    p_d         = p_q;
    fault_map_d = fault_map_q;
    fault_cnt_d = fault_cnt_q;
    map_d       = map_q;
    out_valid_d = 1'b0;
    sum_d       = sum_q;
    cout_d      = cout_q;
    case (state_q)
      S_IDLE, S_READY, S_FAIL: begin
        if (start) begin
          state_d     = S_TEST;
          c_d         = '0;
          p_d         = '0;
          fault_map_d = '0;
          fault_cnt_d = '0;
        end else if (in_valid && state_q != S_FAIL) begin
          out_valid_d = 1'b1;
          sum_d       = add_sum;
          cout_d      = add_carry;
        end
      end
      S_TEST: begin
        if (test_bad) fault_map_d[c_q] = 1'b1;
        p_d = p_q + 3'd1;
        if (p_q == 3'd7) begin
          if (c_q == LAST_CELL) begin
            c_d     = '0;
            state_d = S_MAP;
          end else begin
            c_d = c_q + IW'(1);
          end
        end
      end
      S_MAP: begin
        fault_cnt_d = pop_cnt;
        if (pop_cnt <= SPARES_W) begin
          map_d   = heal_map;
          state_d = S_READY;
        end else begin
          state_d = S_FAIL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      c_q         <= '0;
      p_q         <= '0;
      fault_map_q <= '0;
      fault_cnt_q <= '0;
      for (int i = 0; i < WIDTH; i++) map_q[i] <= IW'(i);
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      p_q         <= p_d;
      fault_map_q <= fault_map_d;
      fault_cnt_q <= fault_cnt_d;
      map_q       <= map_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign busy      = (state_q == S_TEST) || (state_q == S_MAP);
  assign ready     = (state_q == S_READY);
  assign fail      = (state_q == S_FAIL);
  assign fault_map = fault_map_q;
  assign fault_cnt = fault_cnt_q;

endmodule

// File: tb/tb_rca_selfrepair.sv
// tb/tb_rca_selfrepair.sv - directed self-checking bench for rca_selfrepair
module tb_rca_selfrepair;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [3:0] a, b;
  logic       cin;
  logic [5:0] fi_mask;
  logic       out_valid;
  logic [3:0] sum;
  logic       cout;
  logic       busy, ready, fail;
  logic [5:0] fault_map;
  logic [2:0] fault_cnt;

  int checks = 0;
  int errors = 0;

  rca_selfrepair #(.WIDTH(4), .SPARES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .a(a), .b(b), .cin(cin), .fi_mask(fi_mask),
    .out_valid(out_valid), .sum(sum), .cout(cout),
    .busy(busy), .ready(ready), .fail(fail),
    .fault_map(fault_map), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_add(input logic [3:0] av, input logic [3:0] bv, input logic cv);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Pulses start and returns how many sampled cycles busy stayed high (bounded).
  task automatic run_bist(input logic [5:0] mask, output int n);
    fi_mask = mask;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; in_valid = 0; a = 0; b = 0; cin = 0; fi_mask = 0;
    tick(); tick();
    checks++; if ({out_valid, sum, cout, busy, ready, fail} !== 9'b0) begin errors++;
      $display("FAIL reset_outs got %b exp 0", {out_valid, sum, cout, busy, ready, fail}); end
    checks++; if ({fault_map, fault_cnt} !== 9'b0) begin errors++;
      $display("FAIL reset_fault got %b exp 0", {fault_map, fault_cnt}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_identity_add();
    do_add(4'd9, 4'd7, 1'b0);
    checks++; if ({out_valid, sum, cout} !== {1'b1, 4'd0, 1'b1}) begin errors++;
      $display("FAIL identity_add got v=%b s=%0d c=%b exp v=1 s=0 c=1", out_valid, sum, cout); end
    tick();
    checks++; if ({out_valid, sum, cout} !== {1'b0, 4'd0, 1'b1}) begin errors++;
      $display("FAIL add_hold got v=%b s=%0d c=%b exp v=0 s=0 c=1", out_valid, sum, cout); end
  endtask

  task automatic test_bist_clean();
    int n;
    run_bist(6'b000000, n);
    checks++; if (n !== 49) begin errors++; $display("FAIL clean_busy_cycles got %0d exp 49", n); end
    checks++; if ({ready, fail, fault_map, fault_cnt} !== {1'b1, 1'b0, 6'b0, 3'd0}) begin errors++;
      $display("FAIL clean_status got r=%b f=%b map=%b cnt=%0d exp r=1 f=0 map=0 cnt=0", ready, fail, fault_map, fault_cnt); end
    do_add(4'd15, 4'd1, 1'b1);
    checks++; if ({out_valid, sum, cout} !== {1'b1, 4'd1, 1'b1}) begin errors++;
      $display("FAIL clean_add got v=%b s=%0d c=%b exp v=1 s=1 c=1", out_valid, sum, cout); end
  endtask

  task automatic test_single_fault();
    int n;
    run_bist(6'b000100, n);
    checks++; if ({ready, fault_map, fault_cnt} !== {1'b1, 6'b000100, 3'd1}) begin errors++;
      $display("FAIL single_status got r=%b map=%b cnt=%0d exp r=1 map=000100 cnt=1", ready, fault_map, fault_cnt); end
    do_add(4'd5, 4'd6, 1'b0);
    checks++; if ({out_valid, sum, cout} !== {1'b1, 4'd11, 1'b0}) begin errors++;
      $display("FAIL single_add got v=%b s=%0d c=%b exp v=1 s=11 c=0", out_valid, sum, cout); end
  endtask

  task automatic test_two_faults();
    int n;
    run_bist(6'b100001, n);
    checks++; if ({ready, fail, fault_map, fault_cnt} !== {1'b1, 1'b0, 6'b100001, 3'd2}) begin errors++;
      $display("FAIL two_status got r=%b f=%b map=%b cnt=%0d exp r=1 f=0 map=100001 cnt=2", ready, fail, fault_map, fault_cnt); end
    do_add(4'd15, 4'd15, 1'b1);
    checks++; if ({out_valid, sum, cout} !== {1'b1, 4'd15, 1'b1}) begin errors++;
      $display("FAIL two_add got v=%b s=%0d c=%b exp v=1 s=15 c=1", out_valid, sum, cout); end
  endtask

  task automatic test_fail();
    int n;
    run_bist(6'b010101, n);
    checks++; if ({ready, fail, busy, fault_map, fault_cnt} !== {1'b0, 1'b1, 1'b0, 6'b010101, 3'd3}) begin errors++;
      $display("FAIL fail_status got r=%b f=%b busy=%b map=%b cnt=%0d exp r=0 f=1 busy=0 map=010101 cnt=3", ready, fail, busy, fault_map, fault_cnt); end
    do_add(4'd1, 4'd2, 1'b0);
    checks++; if ({out_valid, sum, cout} !== {1'b0, 4'd15, 1'b1}) begin errors++;
      $display("FAIL fail_no_add got v=%b s=%0d c=%b exp v=0 s=15 c=1", out_valid, sum, cout); end
  endtask

  task automatic test_recover();
    int n;
    run_bist(6'b000000, n);
    checks++; if ({n == 49, ready, fail, fault_cnt} !== {1'b1, 1'b1, 1'b0, 3'd0}) begin errors++;
      $display("FAIL recover_status got n=%0d r=%b f=%b cnt=%0d exp n=49 r=1 f=0 cnt=0", n, ready, fail, fault_cnt); end
  endtask

  task automatic test_start_priority();
    int n;
    a = 4'd1; b = 4'd1; cin = 1'b0; fi_mask = 6'b000010;
    start = 1'b1; in_valid = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    checks++; if ({out_valid, busy, ready} !== 3'b010) begin errors++;
      $display("FAIL start_wins got v=%b busy=%b r=%b exp v=0 busy=1 r=0", out_valid, busy, ready); end
    n = 0;
    while (busy && n < 200) begin
      n++;
      start = (n == 10);
      tick();
    end
    start = 1'b0;
    checks++; if (n !== 49) begin errors++; $display("FAIL start_ignored_cycles got %0d exp 49", n); end
    do_add(4'd2, 4'd3, 1'b0);
    checks++; if ({ready, fault_map, out_valid, sum, cout} !== {1'b1, 6'b000010, 1'b1, 4'd5, 1'b0}) begin errors++;
      $display("FAIL prio_add got r=%b map=%b v=%b s=%0d c=%b exp r=1 map=000010 v=1 s=5 c=0", ready, fault_map, out_valid, sum, cout); end
  endtask

  task automatic test_reset_mid_test();
    fi_mask = 6'b000000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, sum, cout, busy, ready, fail, fault_map, fault_cnt} !== 18'b0) begin errors++;
      $display("FAIL mid_reset got %b exp 0", {out_valid, sum, cout, busy, ready, fail, fault_map, fault_cnt}); end
    tick();
    rst_n = 1'b1;
    tick();
    do_add(4'd3, 4'd4, 1'b0);
    checks++; if ({out_valid, sum, cout} !== {1'b1, 4'd7, 1'b0}) begin errors++;
      $display("FAIL post_reset_add got v=%b s=%0d c=%b exp v=1 s=7 c=0", out_valid, sum, cout); end
  endtask

  // Identity map left in place after reset, so a fault on cell 2 is visible: 0+0 -> 1100.
  task automatic test_unrepaired();
    fi_mask = 6'b000100;
    do_add(4'd0, 4'd0, 1'b0);
    checks++; if ({out_valid, sum, cout} !== {1'b1, 4'd12, 1'b0}) begin errors++;
      $display("FAIL unrepaired_add got v=%b s=%0d c=%b exp v=1 s=12 c=0", out_valid, sum, cout); end
    fi_mask = 6'b000000;
  endtask

  initial begin
    test_reset();
    test_identity_add();
    test_bist_clean();
    test_single_fault();
    test_two_faults();
    test_fail();
    test_recover();
    test_start_priority();
    test_reset_mid_test();
    test_unrepaired();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
